// File: rtl/i4_pkg.sv
// Shared types and constants for the i4 priority-match schedulers.
package i4_pkg;

   localparam int unsigned NCH      = 4;
   localparam int unsigned REQ_W    = 8;
   localparam int unsigned HOLD_MAX = 15;
   localparam int unsigned HOLD_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      GRANT = 2'd2
   } state_t;

   typedef logic [1:0] ch_idx_t;

   // Grant payload offered to the downstream service logic
   typedef struct packed {
      ch_idx_t          ch;
      logic [REQ_W-1:0] hits;
   } gnt_t;

endpackage

// File: rtl/i4_rr_pick.sv
// Round-robin selector: first set hit bit at or above ptr, wrapping to 0.
module i4_rr_pick
   import i4_pkg::*;
(
   input  logic [NCH-1:0] hit,
   input  ch_idx_t        ptr,
   output ch_idx_t        idx,
   output logic           found
);

   ch_idx_t cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cand = ptr + ch_idx_t'(i);
         if (!found && hit[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/i4_grant_sched.sv
// Four-channel masked-match scheduler issuing round-robin grants over valid/ready.
module i4_grant_sched
   import i4_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*REQ_W-1:0]   req_a,
   input  logic [NCH*REQ_W-1:0]   req_b,
   input  logic                   cfg_we,
   input  logic [1:0]             cfg_ch,
   input  logic [REQ_W-1:0]       cfg_mask,
   output logic                   gnt_valid,
   input  logic                   gnt_ready,
   output logic [1:0]             gnt_ch,
   output logic [REQ_W-1:0]       gnt_hits,
   output logic                   timeout,
   output logic                   busy
);

   logic [REQ_W-1:0]  mask_q [NCH];
   logic [REQ_W-1:0]  and_v  [NCH];
   logic [NCH-1:0]    hit;

   state_t            state_q, state_d;
   ch_idx_t           rr_q, rr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   gnt_t              gnt_q, gnt_d;
   logic              valid_d, timeout_d, busy_d;

   ch_idx_t           pick_idx;
   logic              pick_found;

   // Per-channel masked match and its OR-reduced hit flag
   always_comb begin
      for (int unsigned c = 0; c < NCH; c++) begin
         and_v[c] = req_a[c*REQ_W +: REQ_W] & req_b[c*REQ_W +: REQ_W] & mask_q[c];
         hit[c]   = |and_v[c];
      end
   end

   // Mask writes land at the edge, so an EVAL in the same cycle still sees the old mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NCH; c++) mask_q[c] <= '1;
      end else if (cfg_we) begin
         mask_q[cfg_ch] <= cfg_mask;
      end
   end

   i4_rr_pick u_pick (
      .hit   (hit),
      .ptr   (rr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         gnt_valid <= valid_d;
         timeout   <= timeout_d;
         busy      <= busy_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      valid_d   = gnt_valid;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (|hit) state_d = EVAL;
         end
         EVAL: begin
            if (pick_found) begin
               gnt_d.ch   = pick_idx;
               gnt_d.hits = and_v[pick_idx];
               valid_d    = 1'b1;
               hold_d     = '0;
               state_d    = GRANT;
            end else begin
               state_d    = IDLE;
            end
         end
         GRANT: begin
            // Acceptance takes precedence over an expiring hold counter
            if (gnt_ready) begin
               valid_d = 1'b0;
               rr_d    = gnt_q.ch + ch_idx_t'(1);
               state_d = IDLE;
            end else if (hold_q == HOLD_W'(HOLD_MAX)) begin
               timeout_d = 1'b1;
               valid_d   = 1'b0;
               rr_d      = gnt_q.ch + ch_idx_t'(1);
               state_d   = IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign gnt_ch   = gnt_q.ch;
   assign gnt_hits = gnt_q.hits;

endmodule

// File: tb/tb_i4_grant_sched.sv
// Randomized and directed bench for i4_grant_sched against a transaction-rule reference model.
module tb_i4_grant_sched;
   import i4_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req_a, req_b;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [7:0]  cfg_mask;
   logic        gnt_valid, gnt_ready;
   logic [1:0]  gnt_ch;
   logic [7:0]  gnt_hits;
   logic        timeout, busy;

   always #5 clk = ~clk;

   i4_grant_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_a     (req_a),
      .req_b     (req_b),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_mask  (cfg_mask),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready),
      .gnt_ch    (gnt_ch),
      .gnt_hits  (gnt_hits),
      .timeout   (timeout),
      .busy      (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase 0 waiting, 1 evaluating, 2 offering a grant
   logic [7:0] m_mask [4];
   int         m_ptr, m_phase, m_patience, m_ch, m_hits;
   bit         m_valid, m_to;

   function automatic int chan_and(input int c);
      logic [7:0] v;
      v = req_a[c*8 +: 8] & req_b[c*8 +: 8] & m_mask[c];
      return int'(v);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) m_mask[c] = 8'hFF;
      m_ptr = 0; m_phase = 0; m_patience = 0;
      m_ch = 0; m_hits = 0; m_valid = 0; m_to = 0;
   endtask

   task automatic model_clock();
      int  hv [4];
      bit  any, found;
      any = 0; found = 0;
      for (int c = 0; c < 4; c++) begin
         hv[c] = chan_and(c);
         if (hv[c] != 0) any = 1;
      end
      m_to = 0;
      if (m_phase == 0) begin
         if (any) m_phase = 1;
      end else if (m_phase == 1) begin
         for (int k = 0; k < 4; k++) begin
            if (!found && hv[(m_ptr + k) % 4] != 0) begin
               found  = 1;
               m_ch   = (m_ptr + k) % 4;
               m_hits = hv[m_ch];
            end
         end
         if (found) begin
            m_valid    = 1;
            m_patience = int'(HOLD_MAX);
            m_phase    = 2;
         end else begin
            m_phase = 0;
         end
      end else begin
         if (gnt_ready) begin
            m_valid = 0; m_ptr = (m_ch + 1) % 4; m_phase = 0;
         end else if (m_patience == 0) begin
            m_to = 1; m_valid = 0; m_ptr = (m_ch + 1) % 4; m_phase = 0;
         end else begin
            m_patience--;
         end
      end
      if (cfg_we) m_mask[cfg_ch] = cfg_mask;
   endtask

   task automatic compare_all();
      check("gnt_valid", 32'(gnt_valid), 32'(m_valid));
      check("gnt_ch",    32'(gnt_ch),    m_ch);
      check("gnt_hits",  32'(gnt_hits),  m_hits);
      check("timeout",   32'(timeout),   32'(m_to));
      check("busy",      32'(busy),      32'(m_phase != 0));
   endtask

   task automatic tick();
      model_clock();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   task automatic set_ch(input int c, input logic [7:0] v);
      req_a[c*8 +: 8] = v;
      req_b[c*8 +: 8] = v;
   endtask

   initial begin
      int      gch [$];
      int      gcy [$];
      int      vcnt, tcnt, first_ch, next_ch, guard, thr;
      bit      seen_to, got_next, got_first;

      rst_n = 1'b0; req_a = '0; req_b = '0; cfg_we = 1'b0; cfg_ch = '0;
      cfg_mask = '0; gnt_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // Single requester on ch2, grant two cycles after the hit
      set_ch(2, 8'h01);
      tick();
      tick();
      check("t1_valid", 32'(gnt_valid), 32'd1);
      check("t1_ch",    32'(gnt_ch),    32'd2);
      check("t1_hits",  32'(gnt_hits),  32'h01);
      gnt_ready = 1'b1;
      tick();
      check("t1_drop", 32'(gnt_valid), 32'd0);
      req_a = '1; req_b = '1;
      tick();
      tick();
      check("t1_ptr3", 32'(gnt_ch), 32'd3);
      tick();
      req_a = '0; req_b = '0; gnt_ready = 1'b0;
      repeat (3) tick();

      // All channels hitting with ready high: strict rotation every three cycles
      req_a = '1; req_b = '1; gnt_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (gnt_valid && gnt_ready) begin
            gch.push_back(int'(gnt_ch));
            gcy.push_back(i);
         end
         tick();
      end
      check("t2_count", 32'(gch.size()), 32'd5);
      for (int i = 0; i < gch.size() && i < 5; i++) begin
         check("t2_order", 32'(gch[i]), 32'(i % 4));
         if (i > 0) check("t2_interval", 32'(gcy[i] - gcy[i-1]), 32'd3);
      end
      req_a = '0; req_b = '0; gnt_ready = 1'b0;
      repeat (3) tick();

      // Masked-off channel never makes the scheduler busy
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mask = 8'h00;
      tick();
      cfg_we = 1'b0;
      set_ch(1, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t3_busy", 32'(busy), 32'd0);
      end
      req_a = '0; req_b = '0;
      cfg_we = 1'b1; cfg_mask = 8'hFF;
      tick();
      cfg_we = 1'b0;

      // Timeout on ch0, then rotation to ch2
      do_reset();
      set_ch(0, 8'h3C);
      set_ch(2, 8'h81);
      vcnt = 0; tcnt = 0; guard = 0; first_ch = -1; next_ch = -1;
      seen_to = 0; got_next = 0; got_first = 0;
      while (!got_next && guard < 60) begin
         tick();
         guard++;
         if (timeout) tcnt++;
         if (!seen_to) begin
            if (gnt_valid) begin
               vcnt++;
               if (!got_first) begin first_ch = int'(gnt_ch); got_first = 1; end
            end
            if (timeout) seen_to = 1;
         end else if (gnt_valid) begin
            next_ch = int'(gnt_ch);
            got_next = 1;
         end
      end
      check("t4_first_ch",  32'(first_ch), 32'd0);
      check("t4_hold",      32'(vcnt),     32'(HOLD_MAX + 1));
      check("t4_timeouts",  32'(tcnt),     32'd1);
      check("t4_next_seen", 32'(got_next), 32'd1);
      check("t4_next_ch",   32'(next_ch),  32'd2);
      gnt_ready = 1'b1;
      tick();
      req_a = '0; req_b = '0; gnt_ready = 1'b0;
      repeat (2) tick();

      // Request withdrawn between IDLE and EVAL
      set_ch(1, 8'h10);
      tick();
      req_a = '0; req_b = '0;
      tick();
      check("t5_valid", 32'(gnt_valid), 32'd0);
      check("t5_busy",  32'(busy),      32'd0);
      repeat (2) tick();

      // Async reset during a ch3 grant
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mask = 8'h00;
      tick();
      cfg_we = 1'b0;
      set_ch(3, 8'h42);
      tick();
      tick();
      check("t6_ch3", 32'(gnt_ch), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_drop", 32'(gnt_valid), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
      req_a = '1; req_b = '1; gnt_ready = 1'b1;
      tick();
      tick();
      check("t6_scan_ch0", 32'(gnt_ch), 32'd0);
      check("t6_valid",    32'(gnt_valid), 32'd1);

      // Randomized traffic, ready probability varied per epoch
      thr = 5;
      for (int i = 0; i < 2000; i++) begin
         if (i % 400 == 0) thr = $urandom_range(0, 9);
         req_a = $urandom;
         req_b = $urandom;
         if ($urandom_range(0, 7) == 0) begin req_a = '0; req_b = '0; end
         gnt_ready = ($urandom_range(0, 9) < thr);
         cfg_we    = ($urandom_range(0, 15) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
